fp_addsub_align_stage: RTL and testbench

- Stage 1 of the pipelined single-precision add/subtract datapath.
- Advances only on the stage-1 enable pulse from the pipeline sequencer FSM.
- Unpacks two IEEE-754 binary32 operands and applies the operation to operand B's sign.
- Orders the operands by magnitude, right-shifts the smaller mantissa by the exponent difference with guard/round/sticky bits, classifies special values, and registers everything for the stage-2 add/normalise block.

---
 rtl/fp_addsub_align_stage.sv | 144 ++++++++++++++
 tb/tb_fp_addsub_align_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_align_stage.sv
// rtl/fp_addsub_align_stage.sv - binary32 add/sub stage 1: unpack, order, align, classify specials
// Optional FP_ALIGN_DENORM_EN keeps exponent-0 fractions as denormals instead of flushing to zero.
module fp_addsub_align_stage #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int EXT_W  = 27
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    enable_stage1,
    input  logic                    in_valid,
    input  logic [EXP_W+FRAC_W:0]   a_in,
    input  logic [EXP_W+FRAC_W:0]   b_in,
    input  logic                    op_sub,
    output logic                    out_valid,
    output logic                    sign_large,
    output logic                    sign_small,
    output logic                    eff_sub,
    output logic [EXP_W-1:0]        exp_large,
    output logic [EXT_W-1:0]        mant_large,
    output logic [EXT_W-1:0]        mant_small_al,
    output logic                    is_nan,
    output logic                    is_inf,
    output logic                    inf_sign
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int GRS_W = EXT_W - FRAC_W - 1;
    localparam logic [EXP_W-1:0] EXT_LIM = EXT_W[EXP_W-1:0];
`ifdef FP_ALIGN_DENORM_EN
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
`endif

    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
    logic [FRAC_W-1:0] fa, fb, fa_eff, fb_eff;
    logic              ha, hb;
    logic              a_nan, b_nan, a_inf, b_inf;
    logic              a_large;

    logic              n_sign_large, n_sign_small, n_eff_sub;
    logic [EXP_W-1:0]  n_exp_large, e_large_eff, e_small_eff, d;
    logic [EXT_W-1:0]  n_mant_large, ext_small, shifted, n_mant_small_al;
    logic              lost;
    logic              n_is_nan, n_is_inf, n_inf_sign;

    always_comb begin
        sa = a_in[W-1];
        sb = b_in[W-1] ^ op_sub;
        ea = a_in[W-2:FRAC_W];
        eb = b_in[W-2:FRAC_W];
        fa = a_in[FRAC_W-1:0];
        fb = b_in[FRAC_W-1:0];
        ha = (ea != '0);
        hb = (eb != '0);
`ifdef FP_ALIGN_DENORM_EN
        // Denormals sit at effective exponent 1 for alignment purposes.
        fa_eff = fa;
        fb_eff = fb;
        ea_eff = ha ? ea : EXP_ONE;
        eb_eff = hb ? eb : EXP_ONE;
`else
        fa_eff = ha ? fa : '0;
        fb_eff = hb ? fb : '0;
        ea_eff = ea;
        eb_eff = eb;
`endif
        a_nan = (ea == '1) && (fa != '0);
        b_nan = (eb == '1) && (fb != '0);
        a_inf = (ea == '1) && (fa == '0);
        b_inf = (eb == '1) && (fb == '0);

        // Ties go to A so that equal magnitudes always produce a stable ordering.
        a_large = {ea, fa_eff} >= {eb, fb_eff};

        if (a_large) begin
            n_sign_large = sa;
            n_sign_small = sb;
            n_exp_large  = ea;
            e_large_eff  = ea_eff;
            e_small_eff  = eb_eff;
            n_mant_large = {ha, fa_eff, {GRS_W{1'b0}}};
            ext_small    = {hb, fb_eff, {GRS_W{1'b0}}};
        end else begin
            n_sign_large = sb;
            n_sign_small = sa;
            n_exp_large  = eb;
            e_large_eff  = eb_eff;
            e_small_eff  = ea_eff;
            n_mant_large = {hb, fb_eff, {GRS_W{1'b0}}};
            ext_small    = {ha, fa_eff, {GRS_W{1'b0}}};
        end
        n_eff_sub = n_sign_large ^ n_sign_small;

        d       = e_large_eff - e_small_eff;
        shifted = ext_small >> d;
        lost    = |(ext_small & ~({EXT_W{1'b1}} << d));
        if (d >= EXT_LIM) begin
            n_mant_small_al = {{(EXT_W-1){1'b0}}, |ext_small};
        end else begin
            n_mant_small_al = {shifted[EXT_W-1:1], shifted[0] | lost};
        end

        n_is_nan   = a_nan || b_nan || (a_inf && b_inf && n_eff_sub);
        n_is_inf   = !n_is_nan && (a_inf || b_inf);
        n_inf_sign = 1'b0;
        if (n_is_inf) begin
            if (a_inf && b_inf) begin
                n_inf_sign = n_sign_large;
            end else if (a_inf) begin
                n_inf_sign = sa;
            end else begin
                n_inf_sign = sb;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            out_valid     <= 1'b0;
            sign_large    <= 1'b0;
            sign_small    <= 1'b0;
            eff_sub       <= 1'b0;
            exp_large     <= '0;
            mant_large    <= '0;
            mant_small_al <= '0;
            is_nan        <= 1'b0;
            is_inf        <= 1'b0;
            inf_sign      <= 1'b0;
        end else if (enable_stage1) begin
            out_valid     <= in_valid;
            sign_large    <= n_sign_large;
            sign_small    <= n_sign_small;
            eff_sub       <= n_eff_sub;
            exp_large     <= n_exp_large;
            mant_large    <= n_mant_large;
            mant_small_al <= n_mant_small_al;
            is_nan        <= n_is_nan;
            is_inf        <= n_is_inf;
            inf_sign      <= n_inf_sign;
        end
    end

endmodule

// File: tb/tb_fp_addsub_align_stage.sv
// tb/tb_fp_addsub_align_stage.sv - directed self-checking bench for fp_addsub_align_stage
module tb_fp_addsub_align_stage;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable_stage1;
    logic        in_valid;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        op_sub;
    logic        out_valid;
    logic        sign_large;
    logic        sign_small;
    logic        eff_sub;
    logic [7:0]  exp_large;
    logic [26:0] mant_large;
    logic [26:0] mant_small_al;
    logic        is_nan;
    logic        is_inf;
    logic        inf_sign;

    int n_cmp = 0;
    int n_bad = 0;

    fp_addsub_align_stage dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .enable_stage1 (enable_stage1),
        .in_valid      (in_valid),
        .a_in          (a_in),
        .b_in          (b_in),
        .op_sub        (op_sub),
        .out_valid     (out_valid),
        .sign_large    (sign_large),
        .sign_small    (sign_small),
        .eff_sub       (eff_sub),
        .exp_large     (exp_large),
        .mant_large    (mant_large),
        .mant_small_al (mant_small_al),
        .is_nan        (is_nan),
        .is_inf        (is_inf),
        .inf_sign      (inf_sign)
    );

    always #5 clk_in = ~clk_in;

    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk_in);
        a_in = a;
        b_in = b;
        op_sub = sub;
        in_valid = 1'b1;
        enable_stage1 = 1'b1;
        @(posedge clk_in);
        #1;
        enable_stage1 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable_stage1 = 1'b0;
        in_valid = 1'b0;
        a_in = 32'h0;
        b_in = 32'h0;
        op_sub = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({out_valid, sign_large, sign_small, eff_sub, exp_large, mant_large, mant_small_al,
             is_nan, is_inf, inf_sign} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: out_valid=%0b exp=%h ml=%h ms=%h", out_valid, exp_large,
                     mant_large, mant_small_al);
        end
    endtask

    task automatic test_align_one;
        pulse(32'h3F800000, 32'h40000000, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL align1_valid: got %0b want 1", out_valid);
        end
        n_cmp++;
        if (exp_large !== 8'h80) begin
            n_bad++; $display("FAIL align1_exp: got %h want 80", exp_large);
        end
        n_cmp++;
        if (mant_large !== 27'h4000000) begin
            n_bad++; $display("FAIL align1_ml: got %h want 4000000", mant_large);
        end
        n_cmp++;
        if (mant_small_al !== 27'h2000000) begin
            n_bad++; $display("FAIL align1_ms: got %h want 2000000", mant_small_al);
        end
        n_cmp++;
        if ({eff_sub, is_nan, is_inf} !== 3'b000) begin
            n_bad++; $display("FAIL align1_flags: got %b want 000", {eff_sub, is_nan, is_inf});
        end
    endtask

    task automatic test_sticky;
        pulse(32'h4B800000, 32'h3F800001, 1'b0);
        n_cmp++;
        if (mant_small_al !== 27'h0000005) begin
            n_bad++; $display("FAIL sticky_ms: got %h want 0000005", mant_small_al);
        end
        n_cmp++;
        if (exp_large !== 8'h97) begin
            n_bad++; $display("FAIL sticky_exp: got %h want 97", exp_large);
        end
    endtask

    task automatic test_large_shift;
        pulse(32'h4F800000, 32'h3F800000, 1'b0);
        n_cmp++;
        if (mant_small_al !== 27'h0000001) begin
            n_bad++; $display("FAIL shift32_ms: got %h want 0000001", mant_small_al);
        end
        pulse(32'h4D000000, 32'h40000000, 1'b0);
        n_cmp++;
        if (mant_small_al !== 27'h0000001) begin
            n_bad++; $display("FAIL shift26_ms: got %h want 0000001", mant_small_al);
        end
        n_cmp++;
        if (exp_large !== 8'h9A) begin
            n_bad++; $display("FAIL shift26_exp: got %h want 9a", exp_large);
        end
    endtask

    task automatic test_tie_sub;
        pulse(32'h40400000, 32'h40400000, 1'b1);
        n_cmp++;
        if ({sign_large, sign_small, eff_sub} !== 3'b011) begin
            n_bad++; $display("FAIL tie_signs: got %b want 011", {sign_large, sign_small, eff_sub});
        end
        n_cmp++;
        if (mant_large !== 27'h6000000 || mant_small_al !== 27'h6000000) begin
            n_bad++; $display("FAIL tie_mants: got %h/%h want 6000000/6000000", mant_large, mant_small_al);
        end
        // Negative B with subtract: -1 - 2 style ordering, B large and its sign flipped
        pulse(32'hBF800000, 32'hC0000000, 1'b1);
        n_cmp++;
        if ({sign_large, sign_small, eff_sub, exp_large} !== {3'b011, 8'h80}) begin
            n_bad++; $display("FAIL negsub: got %b %h want 011 80", {sign_large, sign_small, eff_sub}, exp_large);
        end
    endtask

    task automatic test_specials;
        pulse(32'h7F800000, 32'h7F800000, 1'b1);
        n_cmp++;
        if ({is_nan, is_inf} !== 2'b10) begin
            n_bad++; $display("FAIL inf_minus_inf: got %b want 10", {is_nan, is_inf});
        end
        pulse(32'h7F800000, 32'h7F800000, 1'b0);
        n_cmp++;
        if ({is_nan, is_inf, inf_sign} !== 3'b010) begin
            n_bad++; $display("FAIL inf_plus_inf: got %b want 010", {is_nan, is_inf, inf_sign});
        end
        pulse(32'h7FC00000, 32'h3F800000, 1'b0);
        n_cmp++;
        if ({is_nan, is_inf} !== 2'b10) begin
            n_bad++; $display("FAIL nan_a: got %b want 10", {is_nan, is_inf});
        end
        pulse(32'h3F800000, 32'h7F800000, 1'b1);
        n_cmp++;
        if ({is_nan, is_inf, inf_sign} !== 3'b011) begin
            n_bad++; $display("FAIL finite_minus_inf: got %b want 011", {is_nan, is_inf, inf_sign});
        end
    endtask

    task automatic test_denorm;
        logic [26:0] want_ms;
`ifdef FP_ALIGN_DENORM_EN
        want_ms = 27'h0000001;
`else
        want_ms = 27'h0000000;
`endif
        pulse(32'h00000001, 32'h3F800000, 1'b0);
        n_cmp++;
        if (mant_small_al !== want_ms || exp_large !== 8'h7F) begin
            n_bad++; $display("FAIL denorm_small: got %h exp %h want %h exp 7f", mant_small_al, exp_large, want_ms);
        end
    endtask

    task automatic test_hold;
        pulse(32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk_in);
        a_in = 32'h7FC00000;
        b_in = 32'h12345678;
        op_sub = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            #1;
            n_cmp++;
            if ({out_valid, exp_large, mant_large, mant_small_al, eff_sub, is_nan} !==
                {1'b1, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: valid=%0b exp=%h ml=%h ms=%h want 1 80 4000000 2000000",
                         i, out_valid, exp_large, mant_large, mant_small_al);
            end
        end
    endtask

    task automatic test_reset_priority;
        @(negedge clk_in);
        a_in = 32'hC0400000;
        b_in = 32'h7F800000;
        in_valid = 1'b1;
        enable_stage1 = 1'b1;
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        enable_stage1 = 1'b0;
        n_cmp++;
        if ({out_valid, sign_large, sign_small, eff_sub, exp_large, mant_large, mant_small_al,
             is_nan, is_inf, inf_sign} !== '0) begin
            n_bad++;
            $display("FAIL reset_over_enable: valid=%0b exp=%h ml=%h ms=%h inf=%0b", out_valid,
                     exp_large, mant_large, mant_small_al, is_inf);
        end
    endtask

    initial begin
        test_reset;
        test_align_one;
        test_sticky;
        test_large_shift;
        test_tie_sub;
        test_specials;
        test_denorm;
        test_hold;
        test_reset_priority;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
